// File: rtl/stream_in_mmap_if.sv
// Memory-mapped device bus shared by the rv32 core's peripherals (mmap_dev).
// addr is the byte offset from the device's ADDR_START; rd is combinational with no wait states.
interface mmap_dev;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output re, output we, output addr, output wd, input rd);
    modport slave  (input re, input we, input addr, input wd, output rd);
endinterface

// File: rtl/stream_in_mmap.sv
// Host-to-CPU byte stream: bytes arrive over valid/ready into a FIFO and the core pops them via a
// memory-mapped slave. Define STREAM_IN_IRQ_EN to add the THRESH register and the irq output.
module stream_in_mmap #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    mmap_dev.slave     iface
`ifdef STREAM_IN_IRQ_EN
    ,
    output logic       irq
`endif
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          full;
    logic          empty;
    logic          sel_data;
    logic          sel_status;
    logic          sel_thresh;
    logic          flush;
    logic          push;
    logic          pop;
    logic          unused_bits;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;

    // Word decode; the two byte-lane bits are deliberately ignored.
    assign sel_data    = (iface.addr[31:2] == 30'd0);
    assign sel_status  = (iface.addr[31:2] == 30'd1);
    assign sel_thresh  = (iface.addr[31:2] == 30'd2);
    assign unused_bits = &{1'b0, iface.addr[1:0], iface.wd};

    // Flush wins over both handshakes, so a push in the flush cycle is dropped.
    assign flush = iface.we && sel_status && iface.wd[0];
    assign push  = in_valid && in_ready && !flush;
    assign pop   = iface.re && sel_data && !empty && !flush;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

`ifdef STREAM_IN_IRQ_EN
    logic [CW-1:0] thresh;
    logic [CW-1:0] thresh_next;

    always_comb begin
        thresh_next = thresh;
        if (iface.we && sel_thresh) begin
            thresh_next = iface.wd[CW-1:0];
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
`ifdef STREAM_IN_IRQ_EN
            thresh <= '0;
            irq    <= 1'b0;
`endif
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
            count <= count_next;
`ifdef STREAM_IN_IRQ_EN
            thresh <= thresh_next;
            irq    <= (thresh_next != '0) && (count_next >= thresh_next);
`endif
        end
    end

    // NOTE: the byte storage has no reset; stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_comb begin
        iface.rd = '0;
        if (sel_data) begin
            if (!empty) begin
                iface.rd = {23'b0, 1'b1, mem[rd_ptr]};
            end
        end else if (sel_status) begin
            iface.rd = {16'(count), 14'b0, full, empty};
        end
`ifdef STREAM_IN_IRQ_EN
        else if (sel_thresh) begin
            iface.rd = 32'(thresh);
        end
`endif
    end

`ifndef STREAM_IN_IRQ_EN
    logic unused_sel;
    assign unused_sel = sel_thresh;
`endif

endmodule

// File: tb/tb_stream_in_mmap.sv
// Self-checking bench for stream_in_mmap: a queue-based model checked every cycle plus directed
// literal expectations. Define STREAM_IN_IRQ_EN to also exercise THRESH and irq.
module tb_stream_in_mmap;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
`ifdef STREAM_IN_IRQ_EN
    logic       irq;
`endif

    mmap_dev bus ();

    stream_in_mmap #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .iface    (bus)
`ifdef STREAM_IN_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit model_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the FIFO is simply a queue of bytes.
    logic [7:0]    q[$];
    logic [CW-1:0] m_thresh;
    logic          m_irq;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_thresh = '0;
            m_irq    = 1'b0;
        end else begin
            bit is_full;
            is_full = (q.size() == DEPTH);
            if (bus.we && bus.addr[31:2] == 30'd1 && bus.wd[0]) begin
                q.delete();
            end else begin
                if (bus.re && bus.addr[31:2] == 30'd0 && q.size() != 0) void'(q.pop_front());
                if (in_valid && !is_full) q.push_back(in_data);
            end
`ifdef STREAM_IN_IRQ_EN
            if (bus.we && bus.addr[31:2] == 30'd2) m_thresh = bus.wd[CW-1:0];
            m_irq = (m_thresh != 0) && (q.size() >= int'(m_thresh));
`endif
        end
    end

    function automatic logic [31:0] model_rd();
        int n;
        n = q.size();
        case (bus.addr[31:2])
            30'd0:   return (n != 0) ? (32'h100 | 32'(q[0])) : 32'h0;
            30'd1:   return (n << 16) | ((n == DEPTH) ? 2 : 0) | ((n == 0) ? 1 : 0);
`ifdef STREAM_IN_IRQ_EN
            30'd2:   return 32'(m_thresh);
`endif
            default: return 32'h0;
        endcase
    endfunction

    // One compare process, away from the active edge.
    always @(negedge clk) begin
        if (model_on) begin
            check("model in_ready", {31'b0, in_ready}, {31'b0, q.size() < DEPTH});
            check("model rd", bus.rd, model_rd());
`ifdef STREAM_IN_IRQ_EN
            check("model irq", {31'b0, irq}, {31'b0, m_irq});
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        bus.re   = 1'b0;
        bus.we   = 1'b0;
        bus.wd   = '0;
    endtask

    task automatic push(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic read_data(input string name, input logic [31:0] exp);
        bus.addr = 32'h0;
        bus.re   = 1'b1;
        #1;
        check(name, bus.rd, exp);
        step();
        bus.re = 1'b0;
    endtask

    task automatic read_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.addr = a;
        bus.re   = 1'b1;
        #1;
        check(name, bus.rd, exp);
        bus.re = 1'b0;
    endtask

    task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
        bus.addr = a;
        bus.we   = 1'b1;
        bus.wd   = d;
        step();
        bus.we = 1'b0;
        bus.wd = '0;
    endtask

    initial begin
        reset_n  = 1'b0;
        in_data  = '0;
        bus.addr = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        model_on = 1'b1;

        check("reset in_ready", {31'b0, in_ready}, 32'h1);
        read_reg("reset status", 32'h4, 32'h0000_0001);

        // 1: basic push and pop
        push(8'h68);
        push(8'h69);
        read_data("t1 pop h", 32'h0000_0168);
        read_data("t1 pop i", 32'h0000_0169);
        read_data("t1 empty read", 32'h0000_0000);
        read_reg("t1 status", 32'h4, 32'h0000_0001);

        // 2: fill to full, over-push rejected, drain in order
        for (int i = 0; i < 16; i++) push(8'(i));
        check("t2 in_ready full", {31'b0, in_ready}, 32'h0);
        read_reg("t2 status full", 32'h4, 32'h0010_0002);
        push(8'h99);
        read_reg("t2 status after 17th", 32'h4, 32'h0010_0002);
        for (int i = 0; i < 16; i++) read_data("t2 drain", 32'h100 + 32'(i));

        // 3: pointer wrap
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) push(8'(8'h40 + r * 10 + i));
            for (int i = 0; i < 10; i++) read_data("t3 wrap", 32'h140 + 32'(r * 10 + i));
        end
        read_reg("t3 status", 32'h4, 32'h0000_0001);

        // 4: full FIFO, pop with in_valid in the same cycle
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        bus.addr = 32'h0;
        bus.re   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        #1;
        check("t4 in_ready", {31'b0, in_ready}, 32'h0);
        check("t4 head", bus.rd, 32'h0000_0120);
        step();
        idle();
        read_reg("t4 status 15", 32'h4, 32'h000F_0000);
        push(8'hAA);
        read_reg("t4 status 16", 32'h4, 32'h0010_0002);
        for (int i = 1; i < 16; i++) read_data("t4 drain", 32'h120 + 32'(i));
        read_data("t4 last", 32'h0000_01AA);

        // 5: empty push with DATA read, then push+pop at count 5
        bus.addr = 32'h0;
        bus.re   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        #1;
        check("t5 empty read", bus.rd, 32'h0);
        step();
        idle();
        read_reg("t5 status", 32'h4, 32'h0001_0000);
        read_data("t5 read", 32'h0000_0155);
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
        bus.addr = 32'h0;
        bus.re   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h65;
        #1;
        check("t5 pushpop head", bus.rd, 32'h0000_0160);
        step();
        idle();
        read_reg("t5 status 5", 32'h4, 32'h0005_0000);
        for (int i = 1; i < 6; i++) read_data("t5 drain", 32'h160 + 32'(i));

        // 6: flush with simultaneous push, ignored writes, async reset
        for (int i = 0; i < 3; i++) push(8'(8'h70 + i));
        in_valid = 1'b1;
        in_data  = 8'h77;
        write_reg(32'h4, 32'h1);
        in_valid = 1'b0;
        read_reg("t6 flush status", 32'h4, 32'h0000_0001);
        push(8'h7A);
        write_reg(32'h4, 32'h2);
        write_reg(32'h0, 32'hFF);
        read_reg("t6 no flush", 32'h4, 32'h0001_0000);
        read_reg("t6 unmapped", 32'hC, 32'h0);
        read_data("t6 kept", 32'h0000_017A);
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
        in_valid = 1'b1;
        in_data  = 8'h33;
        #2;
        reset_n = 1'b0;
        #1;
        check("t6 reset in_ready", {31'b0, in_ready}, 32'h1);
        read_reg("t6 reset status", 32'h4, 32'h0000_0001);
        in_valid = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        read_reg("t6 after reset", 32'h4, 32'h0000_0001);

`ifdef STREAM_IN_IRQ_EN
        // 7: threshold interrupt
        write_reg(32'h8, 32'h4);
        read_reg("t7 thresh", 32'h8, 32'h4);
        for (int i = 0; i < 3; i++) push(8'(8'h90 + i));
        check("t7 irq below", {31'b0, irq}, 32'h0);
        push(8'h93);
        check("t7 irq at", {31'b0, irq}, 32'h1);
        read_data("t7 pop", 32'h0000_0190);
        check("t7 irq cleared", {31'b0, irq}, 32'h0);
        write_reg(32'h8, 32'h0);
        for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
        check("t7 irq disabled", {31'b0, irq}, 32'h0);
`else
        write_reg(32'h8, 32'h4);
        read_reg("t7 no thresh", 32'h8, 32'h0);
`endif

        step();
        model_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
